io_pattern_macro: RTL and testbench

IO_PATTERN_MACRO -- requirements
Module: io_pattern_macro

---
 rtl/io_pattern_pkg.sv | 27 ++
 rtl/io_pattern_timer.sv | 42 ++++
 rtl/io_pattern_macro.sv | 195 +++++++++++++++++++
 tb/tb_io_pattern_macro.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pattern_pkg.sv
// Shared types and helpers for the IO pattern macro.
// The optional loopback checker is enabled with IO_PATTERN_LOOPBACK_EN.
package io_pattern_pkg;

    localparam int unsigned MAX_PAD_W = 64;
    localparam int unsigned ERR_W     = 16;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One-hot vector with the set bit at pos mod w; callers truncate to w bits.
    function automatic logic [MAX_PAD_W-1:0] onehot_rot(input int unsigned pos,
                                                        input int unsigned w);
        onehot_rot = MAX_PAD_W'(1) << (pos % w);
    endfunction

endpackage

// File: rtl/io_pattern_timer.sv
// Step prescaler: counts 0..div while enabled and flags the terminal count.
module io_pattern_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_c
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_c = en_i && (cnt_q == div_q);

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            div_d = div_i;
            cnt_d = '0;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_pattern_macro.sv
// Pad pattern generator driving east/west/north pad groups with static, walking or counting patterns.
// Defining IO_PATTERN_LOOPBACK_EN adds pad inputs and a saturating loopback error counter.
module io_pattern_macro
    import io_pattern_pkg::*;
#(
    parameter int unsigned NUMBER  = 0,
    parameter int unsigned EAST_W  = 14,
    parameter int unsigned WEST_W  = 14,
    parameter int unsigned NORTH_W = 10,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned LEN_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         mode_i,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic               stop_i,
    output logic [EAST_W-1:0]  IO_east_o,
    output logic [EAST_W-1:0]  IO_east_oe,
    output logic [WEST_W-1:0]  IO_west_o,
    output logic [WEST_W-1:0]  IO_west_oe,
    output logic [NORTH_W-1:0] IO_north_o,
    output logic [NORTH_W-1:0] IO_north_oe,
`ifdef IO_PATTERN_LOOPBACK_EN
    input  logic [EAST_W-1:0]  IO_east_i,
    input  logic [WEST_W-1:0]  IO_west_i,
    input  logic [NORTH_W-1:0] IO_north_i,
    output logic [ERR_W-1:0]   err_cnt_o,
`endif
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [EAST_W-1:0]  east_q, east_d, east_oe_q, east_oe_d;
    logic [WEST_W-1:0]  west_q, west_d, west_oe_q, west_oe_d;
    logic [NORTH_W-1:0] north_q, north_d, north_oe_q, north_oe_d;
    logic               accept_c;
    logic               tick_c;
    logic               run_c;

    // Pattern for one pad group of width w; the caller truncates to w bits.
    function automatic logic [MAX_PAD_W-1:0] pad_pattern(input mode_e m,
                                                         input int unsigned w,
                                                         input logic [LEN_W-1:0] s);
        int unsigned pos;
        pos = NUMBER + 32'(s);
        case (m)
            MODE_STATIC: pad_pattern = onehot_rot(NUMBER, w);
            MODE_WALK:   pad_pattern = onehot_rot(pos, w);
            MODE_COUNT:  pad_pattern = MAX_PAD_W'(pos);
            default:     pad_pattern = '0;
        endcase
    endfunction

    assign run_c = (state_q == ST_RUN);

    io_pattern_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (accept_c),
        .clear_i (run_c && stop_i),
        .en_i    (run_c),
        .div_i   (div_i),
        .tick_c  (tick_c)
    );

    // Next state, captured run parameters and step counter.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        len_d    = len_q;
        step_d   = step_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept_c = 1'b1;
                    mode_d   = mode_e'(mode_i);
                    len_d    = len_i;
                    step_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (len_q == '0) begin
                    state_d = ST_DONE;
                end else if (tick_c) begin
                    if (step_q == LEN_W'(len_q - LEN_W'(1))) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + LEN_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pads follow the next step so the first pattern lands with the first RUN cycle.
    always_comb begin
        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        east_d     = east_q;
        west_d     = west_q;
        north_d    = north_q;
        east_oe_d  = {EAST_W{mode_d != MODE_OFF}};
        west_oe_d  = {WEST_W{mode_d != MODE_OFF}};
        north_oe_d = {NORTH_W{mode_d != MODE_OFF}};
        if (state_d == ST_RUN) begin
            east_d  = EAST_W'(pad_pattern(mode_d, EAST_W, step_d));
            west_d  = WEST_W'(pad_pattern(mode_d, WEST_W, step_d));
            north_d = NORTH_W'(pad_pattern(mode_d, NORTH_W, step_d));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_OFF;
            len_q      <= '0;
            step_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            east_q     <= '0;
            west_q     <= '0;
            north_q    <= '0;
            east_oe_q  <= '0;
            west_oe_q  <= '0;
            north_oe_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            step_q     <= step_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            east_q     <= east_d;
            west_q     <= west_d;
            north_q    <= north_d;
            east_oe_q  <= east_oe_d;
            west_oe_q  <= west_oe_d;
            north_oe_q <= north_oe_d;
        end
    end

    assign IO_east_o   = east_q;
    assign IO_east_oe  = east_oe_q;
    assign IO_west_o   = west_q;
    assign IO_west_oe  = west_oe_q;
    assign IO_north_o  = north_q;
    assign IO_north_oe = north_oe_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef IO_PATTERN_LOOPBACK_EN
    logic [ERR_W-1:0] err_q, err_d;
    logic             mismatch_c;

    // One error per tick on which any pad group reads back differently from what is driven.
    always_comb begin
        err_d      = err_q;
        mismatch_c = (IO_east_i != east_q) || (IO_west_i != west_q) ||
                     (IO_north_i != north_q);
        if (accept_c) begin
            err_d = '0;
        end else if (tick_c && mismatch_c && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_io_pattern_macro.sv
// Directed bench for io_pattern_macro using three instances (NUMBER = 3, 8, 5) sharing one stimulus.
// With IO_PATTERN_LOOPBACK_EN the NUMBER=3 instance is looped back with east bit 0 stuck high.
module tb_io_pattern_macro;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = 8'd0;
    logic [7:0]  div_i = 8'd0;
    logic        stop_i = 1'b0;

    logic [13:0] e3, e3_oe, w3, w3_oe, e8, e8_oe, w8, w8_oe, e5, e5_oe, w5, w5_oe;
    logic [9:0]  n3, n3_oe, n8, n8_oe, n5, n5_oe;
    logic        busy3, done3, busy8, done8, busy5, done5;

    int checks = 0;
    int errors = 0;

    logic [9:0]  walk_n [4] = '{10'h100, 10'h200, 10'h001, 10'h002};
    logic [13:0] walk_e [4] = '{14'h0100, 14'h0200, 14'h0400, 14'h0800};

`ifdef IO_PATTERN_LOOPBACK_EN
    logic [15:0] err3, err8, err5;
    logic [13:0] e3_lb;
    assign e3_lb = {e3[13:1], 1'b1};
`endif

    always #5 clk_i = ~clk_i;

    io_pattern_macro #(.NUMBER(3)) u3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .start_i(start_i),
        .len_i(len_i), .div_i(div_i), .stop_i(stop_i),
        .IO_east_o(e3), .IO_east_oe(e3_oe), .IO_west_o(w3), .IO_west_oe(w3_oe),
        .IO_north_o(n3), .IO_north_oe(n3_oe),
`ifdef IO_PATTERN_LOOPBACK_EN
        .IO_east_i(e3_lb), .IO_west_i(w3), .IO_north_i(n3), .err_cnt_o(err3),
`endif
        .busy_o(busy3), .done_o(done3)
    );

    io_pattern_macro #(.NUMBER(8)) u8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .start_i(start_i),
        .len_i(len_i), .div_i(div_i), .stop_i(stop_i),
        .IO_east_o(e8), .IO_east_oe(e8_oe), .IO_west_o(w8), .IO_west_oe(w8_oe),
        .IO_north_o(n8), .IO_north_oe(n8_oe),
`ifdef IO_PATTERN_LOOPBACK_EN
        .IO_east_i(e8), .IO_west_i(w8), .IO_north_i(n8), .err_cnt_o(err8),
`endif
        .busy_o(busy8), .done_o(done8)
    );

    io_pattern_macro #(.NUMBER(5)) u5 (
        .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .start_i(start_i),
        .len_i(len_i), .div_i(div_i), .stop_i(stop_i),
        .IO_east_o(e5), .IO_east_oe(e5_oe), .IO_west_o(w5), .IO_west_oe(w5_oe),
        .IO_north_o(n5), .IO_north_oe(n5_oe),
`ifdef IO_PATTERN_LOOPBACK_EN
        .IO_east_i(e5), .IO_west_i(w5), .IO_north_i(n5), .err_cnt_o(err5),
`endif
        .busy_o(busy5), .done_o(done5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_i);
    endtask

    task automatic go(input logic [1:0] m, input logic [7:0] l, input logic [7:0] d);
        mode_i  = m;
        len_i   = l;
        div_i   = d;
        start_i = 1'b1;
    endtask

    initial begin
        // Reset values
        nxt();
        chk("rst_east", 32'(e3), 0);
        chk("rst_east_oe", 32'(e3_oe), 0);
        chk("rst_north", 32'(n3), 0);
        chk("rst_busy", 32'(busy3), 0);
        chk("rst_done", 32'(done3), 0);
        rst_ni = 1'b1;
        nxt();

        // STATIC, NUMBER=3, len=2, div=0
        go(2'd1, 8'd2, 8'd0);
        nxt();
        start_i = 1'b0;
        chk("static_east", 32'(e3), 32'h0008);
        chk("static_north", 32'(n3), 32'h008);
        chk("static_east_oe", 32'(e3_oe), 32'h3fff);
        chk("static_north_oe", 32'(n3_oe), 32'h3ff);
        chk("static_busy1", 32'(busy3), 1);
        chk("static_done1", 32'(done3), 0);
        nxt();
        chk("static_busy2", 32'(busy3), 1);
        chk("static_east2", 32'(e3), 32'h0008);
        nxt();
        chk("static_busy3", 32'(busy3), 0);
        chk("static_done3", 32'(done3), 1);
        nxt();
        chk("static_done4", 32'(done3), 0);
        chk("static_hold_east", 32'(e3), 32'h0008);
        chk("static_hold_oe", 32'(e3_oe), 32'h3fff);

        // WALK, NUMBER=8, len=4, div=0
        go(2'd2, 8'd4, 8'd0);
        nxt();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("walk_north%0d", i), 32'(n8), 32'(walk_n[i]));
            chk($sformatf("walk_east%0d", i), 32'(e8), 32'(walk_e[i]));
            chk($sformatf("walk_busy%0d", i), 32'(busy8), 1);
            nxt();
        end
        chk("walk_done", 32'(done8), 1);
        chk("walk_busy_end", 32'(busy8), 0);
        nxt();

        // COUNT, NUMBER=5, len=3, div=2; parameter changes and start mid-run are ignored
        go(2'd3, 8'd3, 8'd2);
        nxt();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("count_east%0d", i), 32'(e5), 32'(5 + i / 3));
            chk($sformatf("count_north%0d", i), 32'(n5), 32'(5 + i / 3));
            chk($sformatf("count_busy%0d", i), 32'(busy5), 1);
            chk($sformatf("count_done%0d", i), 32'(done5), 0);
            mode_i  = 2'd0;
            len_i   = 8'd1;
            div_i   = 8'd0;
            start_i = (i == 1);
            nxt();
        end
        start_i = 1'b0;
        chk("count_done", 32'(done5), 1);
        chk("count_busy_end", 32'(busy5), 0);
        nxt();

        // WALK, NUMBER=3, len=10, stop on RUN cycle 4
        go(2'd2, 8'd10, 8'd0);
        nxt();
        start_i = 1'b0;
        chk("stop_east1", 32'(e3), 32'h0008);
        nxt();
        nxt();
        nxt();
        chk("stop_east4", 32'(e3), 32'h0040);
        stop_i = 1'b1;
        nxt();
        stop_i = 1'b0;
        chk("stop_busy", 32'(busy3), 0);
        chk("stop_done", 32'(done3), 0);
        chk("stop_hold", 32'(e3), 32'h0040);
        nxt();
        chk("stop_done_late", 32'(done3), 0);

        // len=0 run with stop asserted together with start
        go(2'd2, 8'd0, 8'd0);
        stop_i = 1'b1;
        nxt();
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("len0_busy", 32'(busy3), 1);
        chk("len0_east", 32'(e3), 32'h0008);
        nxt();
        chk("len0_done", 32'(done3), 1);
        chk("len0_busy_end", 32'(busy3), 0);
        nxt();
        chk("len0_done_end", 32'(done3), 0);

        // Asynchronous reset mid-run
        go(2'd2, 8'd10, 8'd0);
        nxt();
        start_i = 1'b0;
        chk("arst_busy_before", 32'(busy3), 1);
        nxt();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_east", 32'(e3), 0);
        chk("arst_east_oe", 32'(e3_oe), 0);
        chk("arst_north_oe", 32'(n3_oe), 0);
        chk("arst_busy", 32'(busy3), 0);
        nxt();
        rst_ni = 1'b1;
        nxt();
        chk("arst_done_after", 32'(done3), 0);

        // OFF run drives nothing
        go(2'd0, 8'd2, 8'd0);
        nxt();
        start_i = 1'b0;
        chk("off_busy", 32'(busy3), 1);
        chk("off_east", 32'(e3), 0);
        chk("off_west_oe", 32'(w3_oe), 0);
        nxt();
        nxt();
        chk("off_done", 32'(done3), 1);
        chk("off_north", 32'(n3), 0);
        chk("off_north_oe", 32'(n3_oe), 0);
        nxt();

`ifdef IO_PATTERN_LOOPBACK_EN
        // Loopback, east bit 0 stuck high, WALK len=14 over every east bit
        go(2'd2, 8'd14, 8'd0);
        nxt();
        start_i = 1'b0;
        repeat (15) nxt();
        chk("lb_err_cnt", 32'(err3), 13);
        chk("lb_err_clean", 32'(err8), 0);
        nxt();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
